// File: rtl/commit_trace_unit_if.sv
// Commit/trace bus for commit_trace_unit.
// "master" is the trace unit itself: it takes the commit bus and sources the trace stream.
// "slave" is the CPU/checker side, which drives commits and consumes trace records.
// Handshake: a trace record transfers on a rising edge where trace_valid_o && trace_ready_i.
// trace_valid_o never depends combinationally on trace_ready_i.
interface commit_trace_unit_if #(
  parameter int SEQ_W = 16
);
  logic             commit_valid_i;
  logic [31:0]      commit_pc_i;
  logic [31:0]      commit_npc_i;
  logic [31:0]      commit_instr_i;
  logic             commit_we_i;
  logic [4:0]       commit_rd_i;
  logic [31:0]      commit_wdata_i;
  logic             trace_valid_o;
  logic             trace_ready_i;
  logic [SEQ_W-1:0] trace_seq_o;
  logic [31:0]      trace_pc_o;
  logic [31:0]      trace_npc_o;
  logic [31:0]      trace_instr_o;
  logic             trace_we_o;
  logic [4:0]       trace_rd_o;
  logic [31:0]      trace_wdata_o;

  modport master (
    input  commit_valid_i, commit_pc_i, commit_npc_i, commit_instr_i,
           commit_we_i, commit_rd_i, commit_wdata_i, trace_ready_i,
    output trace_valid_o, trace_seq_o, trace_pc_o, trace_npc_o,
           trace_instr_o, trace_we_o, trace_rd_o, trace_wdata_o
  );

  modport slave (
    output commit_valid_i, commit_pc_i, commit_npc_i, commit_instr_i,
           commit_we_i, commit_rd_i, commit_wdata_i, trace_ready_i,
    input  trace_valid_o, trace_seq_o, trace_pc_o, trace_npc_o,
           trace_instr_o, trace_we_o, trace_rd_o, trace_wdata_o
  );
endinterface

// File: rtl/commit_trace_unit.sv
// commit_trace_unit: captures one commit record per retired instruction into a
// first-word-fall-through FIFO and streams it to the checker over valid/ready.
// Records that find the FIFO full (with no pop on the same edge) are dropped,
// counted, and leave a gap in the sequence stamps.
// Optional feature macro: TRACE_CHECKSUM_EN (running XOR checksum of accepted commits).
module commit_trace_unit #(
  parameter int DEPTH       = 8,
  parameter int SEQ_W       = 16,
  parameter int ALMOST_FULL = DEPTH - 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  commit_trace_unit_if.master   bus,
  output logic                  stall_o,
  output logic                  overflow_o,
  output logic [SEQ_W-1:0]      drop_cnt_o,
  output logic [31:0]           checksum_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_AF    = (AW+1)'(ALMOST_FULL);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [31:0]      pc;
    logic [31:0]      npc;
    logic [31:0]      instr;
    logic             we;
    logic [4:0]       rd;
    logic [31:0]      wdata;
  } rec_t;

  rec_t             r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [SEQ_W-1:0] r_seq;
  logic [SEQ_W-1:0] r_drop_cnt;
  logic             r_overflow;

  logic w_valid;
  logic w_pop;
  logic w_accept;
  logic w_drop;
  rec_t w_rec;
  rec_t w_head;

  // Handshake decode and the record as it will be stored (r0 never reports a write).
  always_comb begin
    w_valid  = (r_count != '0);
    w_pop    = w_valid && bus.trace_ready_i;
    w_accept = bus.commit_valid_i && ((r_count < L_DEPTH) || w_pop);
    w_drop   = bus.commit_valid_i && !w_accept;
    w_rec.seq   = r_seq;
    w_rec.pc    = bus.commit_pc_i;
    w_rec.npc   = bus.commit_npc_i;
    w_rec.instr = bus.commit_instr_i;
    w_rec.we    = bus.commit_we_i && (bus.commit_rd_i != 5'd0);
    w_rec.rd    = bus.commit_rd_i;
    w_rec.wdata = bus.commit_wdata_i;
    w_head      = w_valid ? r_mem[r_rd_ptr] : '0;
  end

  // Record storage; entries are only observable once counted, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (w_accept) r_mem[r_wr_ptr] <= w_rec;
  end

  // Pointers, occupancy, sequence stamp, and drop bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_accept && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_accept && w_pop) r_count <= r_count - 1'b1;
      if (bus.commit_valid_i) r_seq <= r_seq + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

`ifdef TRACE_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running checksum over accepted commits only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         r_checksum <= '0;
    else if (w_accept) r_checksum <= r_checksum ^ w_rec.pc ^ (w_rec.we ? w_rec.wdata : 32'd0);
  end

  assign checksum_o = r_checksum;
`else
  assign checksum_o = 32'd0;
`endif

  assign bus.trace_valid_o = w_valid;
  assign bus.trace_seq_o   = w_head.seq;
  assign bus.trace_pc_o    = w_head.pc;
  assign bus.trace_npc_o   = w_head.npc;
  assign bus.trace_instr_o = w_head.instr;
  assign bus.trace_we_o    = w_head.we;
  assign bus.trace_rd_o    = w_head.rd;
  assign bus.trace_wdata_o = w_head.wdata;
  assign stall_o           = (r_count >= L_AF);
  assign overflow_o        = r_overflow;
  assign drop_cnt_o        = r_drop_cnt;
endmodule
